// File: rtl/div_iter_unit.sv
// Iterative radix-2 restoring divider for DIV/DIVU in the EX stage.
// Stalls the pipeline while a divide is in flight. When it finishes it
// delivers the quotient on lo_o and the remainder on hi_o for the HI/LO write.
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | no divide in flight; a start either launches BUSY or, for a
//        | zero divisor, goes straight to DONE
// BUSY   | one quotient bit per cycle, WIDTH cycles in total
// DONE   | hi_o/lo_o just loaded, div_validE high for this single cycle
module div_iter_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flushE,
  input  logic             startE,
  input  logic             signedE,
  input  logic [WIDTH-1:0] src_aE,
  input  logic [WIDTH-1:0] src_bE,
  output logic             div_stallE,
  output logic             div_validE,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_e;

  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  // dvd_q starts as |dividend| and collects quotient bits shifted in at the LSB
  logic [WIDTH-1:0] dvd_q, dvd_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             neg_quo_q, neg_quo_d;
  logic             neg_rem_q, neg_rem_d;
  logic             valid_q, valid_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;

  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH:0]   part;
  logic             fits;
  logic [WIDTH-1:0] step_rem, step_quo;
  logic [WIDTH-1:0] rem_final, quo_final;

  // operand magnitudes; DIVU takes the raw bit patterns
  always_comb begin
    a_mag = (signedE && src_aE[WIDTH-1]) ? (~src_aE + 1'b1) : src_aE;
    b_mag = (signedE && src_bE[WIDTH-1]) ? (~src_bE + 1'b1) : src_bE;
  end

  // one restoring step; part is one bit wider so a divisor with its MSB set still compares correctly
  always_comb begin
    part     = {rem_q, dvd_q[WIDTH-1]};
    fits     = (part >= {1'b0, dvs_q});
    // the true difference is below the divisor, so the low WIDTH bits are exact
    step_rem = fits ? (part[WIDTH-1:0] - dvs_q) : part[WIDTH-1:0];
    step_quo = {dvd_q[WIDTH-2:0], fits};
    quo_final = neg_quo_q ? (~step_quo + 1'b1) : step_quo;
    rem_final = neg_rem_q ? (~step_rem + 1'b1) : step_rem;
  end

  // next-state and datapath update; flush wins over every state
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    dvd_d     = dvd_q;
    dvs_d     = dvs_q;
    rem_d     = rem_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    valid_d   = 1'b0;
    hi_d      = hi_q;
    lo_d      = lo_q;

    if (flushE) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (startE) begin
            if (src_bE == '0) begin
              // divide by zero has a defined result and skips the iterations
              state_d = S_DONE;
              valid_d = 1'b1;
              lo_d    = '1;
              hi_d    = src_aE;
            end else begin
              state_d   = S_BUSY;
              neg_quo_d = signedE & (src_aE[WIDTH-1] ^ src_bE[WIDTH-1]);
              neg_rem_d = signedE & src_aE[WIDTH-1];
              dvd_d     = a_mag;
              dvs_d     = b_mag;
              rem_d     = '0;
              cnt_d     = '0;
            end
          end
        end
        S_BUSY: begin
          rem_d = step_rem;
          dvd_d = step_quo;
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == LAST_ITER) begin
            state_d = S_DONE;
            valid_d = 1'b1;
            hi_d    = rem_final;
            lo_d    = quo_final;
          end
        end
        S_DONE: begin
          // the divide instruction leaves EX this cycle; startE refers to it
          state_d = S_IDLE;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  // stall drops as soon as a flush is seen in IDLE; in BUSY the pipeline flush overrides it
  always_comb begin
    div_stallE = ((state_q == S_IDLE) && startE && !flushE) || (state_q == S_BUSY);
  end

  // state and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      dvd_q     <= '0;
      dvs_q     <= '0;
      rem_q     <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      valid_q   <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      dvd_q     <= dvd_d;
      dvs_q     <= dvs_d;
      rem_q     <= rem_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      valid_q   <= valid_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
    end
  end

  assign div_validE = valid_q;
  assign hi_o       = hi_q;
  assign lo_o       = lo_q;

endmodule
